cim_mem_arbiter: RTL
====================

Name: cim_mem_arbiter

Overview:
- Arbitrates the single-port temporary-result storage between the CiM's memory-access sources: bus FSM, logic FSM, data-fill FSM, dense broadcast-save FSM, MAC, layernorm and softmax.
- Grants at most one read or write per cycle, round-robin, and drives the storage port.
- Routes read data back to the granted source after a fixed memory latency, tagged one-hot.
- Counts stall cycles and flags protocol errors for debug.

Parameters:
- NUM_SRC, 7, number of requesters; index order equals MEM_ACCESS_SRC_T.
- ADDR_W, 11, width of a temp-result address (TEMP_RES_ADDR_T).
- DATA_W, 16, width of a storage word (STORAGE_WORD_T).
- READ_LATENCY, 2, cycles from mem_en with mem_we=0 to valid mem_rdata; allowed range 1..4.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- read_req  in  NUM_SRC  per-source read request, held until granted
- write_req  in  NUM_SRC  per-source write request, held until granted
- addr_in  in  NUM_SRC*ADDR_W  per-source address; source i occupies bits [i*ADDR_W +: ADDR_W]
- wdata_in  in  NUM_SRC*DATA_W  per-source write data, packed the same way
- grant  out  NUM_SRC  one-hot, combinational; the request of that source is accepted this cycle
- mem_en  out  1  storage port enable
- mem_we  out  1  storage write enable
- mem_addr  out  ADDR_W  storage address
- mem_wdata  out  DATA_W  storage write data
- mem_rdata  in  DATA_W  storage read data
- rd_valid  out  NUM_SRC  one-hot, registered; rd_data belongs to this source
- rd_data  out  DATA_W  registered read data
- stall_cnt  out  STALL_CNT_W  saturating count of cycles in which at least one request was not granted
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, rst=1), all registers cleared:
  - rr_ptr=0, read return pipeline empty, rd_valid=0, rd_data=0, stall_cnt=0, proto_err=0.
  - While rst=1, grant=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - A read in flight when reset asserts is dropped; no rd_valid is produced for it.
- Request vector: req[i] = read_req[i] | write_req[i].
- Arbitration, combinational:
  - Search from index rr_ptr upward, wrapping modulo NUM_SRC; the first i with req[i]=1 is granted.
  - grant=0 if no request is pending.
- Port drive, same cycle as grant:
  - mem_en=|grant.
  - mem_we=write_req[g].
  - mem_addr=addr_in[g], mem_wdata=wdata_in[g].
  - If nothing is granted, mem_addr and mem_wdata are 0.
- Pointer update:
  - On a grant to g, rr_ptr <= (g+1) mod NUM_SRC at the clock edge.
  - Otherwise rr_ptr holds.
  - A source that keeps requesting is therefore served at most once per NUM_SRC grants while others wait. Worst-case wait is NUM_SRC-1 cycles.
- Read return:
  - A granted read pushes the one-hot source tag into a READ_LATENCY-deep shift pipeline.
  - When the tag emerges, mem_rdata is captured: rd_valid=tag and rd_data=mem_rdata, one cycle after the data is valid.
  - Total latency from grant to rd_valid is READ_LATENCY+1 cycles.
  - Back-to-back reads are fully pipelined: one return per cycle.
  - rd_data holds its last value when rd_valid=0.
- Requester contract:
  - Hold the request, address and data stable until grant. Drop the request in the cycle after grant, or keep it asserted for the next access.
  - A read and a write from different sources are simply arbitrated.
- Simultaneous read_req[i] and write_req[i] from the same source:
  - The write is performed (mem_we=1) and the read is ignored.
  - proto_err sets.
- proto_err also sets if any request is withdrawn before grant, i.e. req[i] falls while grant[i]=0 in the preceding cycle.
- proto_err clears only on reset.
- stall_cnt increments in any cycle where (req & ~grant) != 0 and saturates at all-ones.

Test Plan:
- Reset with idle inputs: read_req=0, write_req=0 -> all outputs 0 and mem_en=0 for 10 cycles; stall_cnt=0.
- Single read, source MAC (4), addr=0x123, READ_LATENCY=2, mem model returns 0xBEEF -> cycle0 grant=7'b0010000, mem_en=1, mem_we=0, mem_addr=0x123; cycle3 rd_valid=7'b0010000, rd_data=0xBEEF.
- All 7 sources request reads continuously from reset -> grants in order 0,1,2,3,4,5,6,0,...; each rd_valid is the matching one-hot 3 cycles later; stall_cnt=7 after cycles 0..6.
- Source 2 writes addr=0x010 data=0x00AA while source 5 reads addr=0x010 in the same cycle, rr_ptr=0 -> write granted first, read in the next cycle; read returns 0x00AA.
- Source 1 asserts read_req and write_req together -> write performed, proto_err=1 and held until rst.
- Assert rst for one cycle while 2 reads are in flight -> no rd_valid afterwards; rr_ptr=0, so the next request from source 0 is granted first.

Source files
------------

// File: rtl/cim_mem_arbiter.sv
// cim_mem_arbiter
// Round-robin arbiter for the single-port temporary-result storage shared by
// the CiM memory-access sources (bus FSM, logic FSM, data-fill FSM, dense
// broadcast-save FSM, MAC, layernorm, softmax; index order = source enum).
// At most one read or write is granted per cycle and drives the storage port
// in the same cycle. Read data is routed back to the requesting source after
// the memory latency, tagged with a one-hot rd_valid.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   read_req, write_req    per-source requests, held until granted
//   addr_in, wdata_in      per-source address / write data, source i at [i*W +: W]
//   grant                  one-hot combinational grant
//   mem_en/we/addr/wdata   storage port drive
//   mem_rdata              storage read data, READ_LATENCY cycles after a read
//   rd_valid, rd_data      registered one-hot read return tag and data
//   stall_cnt              saturating count of cycles with an ungranted request
//   proto_err              sticky requester-protocol violation flag
module cim_mem_arbiter #(
  parameter int NUM_SRC      = 7,
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 2,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        read_req,
  input  logic [NUM_SRC-1:0]        write_req,
  input  logic [NUM_SRC*ADDR_W-1:0] addr_in,
  input  logic [NUM_SRC*DATA_W-1:0] wdata_in,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_SRC-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [STALL_CNT_W-1:0]    stall_cnt,
  output logic                      proto_err
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]     rr_ptr_reg;
  logic [PTR_W-1:0]     rr_ptr_next;
  logic [PTR_W-1:0]     grant_idx;
  logic [NUM_SRC-1:0]   req;
  logic [2*NUM_SRC-1:0] req_dbl;
  logic [2*NUM_SRC-1:0] grant_dbl;
  logic [NUM_SRC-1:0]   req_rot;
  logic [NUM_SRC-1:0]   grant_rot;
  logic [NUM_SRC-1:0]   rd_tag;
  logic [NUM_SRC-1:0]   req_prev_reg;
  logic [NUM_SRC-1:0]   grant_prev_reg;
  logic [NUM_SRC-1:0]   tag_pipe_reg [READ_LATENCY];
  logic [ADDR_W-1:0]    addr_arr [NUM_SRC];
  logic [DATA_W-1:0]    wdata_arr [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr_in[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = wdata_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign req = read_req | write_req;

  // Rotate requests right by rr_ptr so bit 0 is the highest-priority source;
  // the lowest set bit then wins, and rotating back left restores the index.
  assign req_dbl = {req, req} >> rr_ptr_reg;
  assign req_rot = req_dbl[NUM_SRC-1:0];

  always_comb begin
    grant_rot = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) grant_rot = NUM_SRC'(1) << k;
    end
  end

  assign grant_dbl = {grant_rot, grant_rot} << rr_ptr_reg;
  assign grant     = rst ? '0 : grant_dbl[2*NUM_SRC-1:NUM_SRC];

  // Grant is one-hot, so a plain priority scan acts as the port mux.
  always_comb begin
    grant_idx = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
        mem_addr  = addr_arr[i];
        mem_wdata = wdata_arr[i];
      end
    end
  end

  assign mem_en = |grant;
  // A source raising both requests gets its write; the read is discarded.
  assign mem_we = |(grant & write_req);
  assign rd_tag = grant & read_req & ~write_req;

  assign rr_ptr_next = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      rd_valid       <= '0;
      rd_data        <= '0;
      stall_cnt      <= '0;
      proto_err      <= 1'b0;
      req_prev_reg   <= '0;
      grant_prev_reg <= '0;
      for (int s = 0; s < READ_LATENCY; s++) tag_pipe_reg[s] <= '0;
    end else begin
      if (mem_en) rr_ptr_reg <= rr_ptr_next;

      // Tag shift pipeline: the tag leaves the last stage in the same cycle
      // the storage presents the matching read data.
      tag_pipe_reg[0] <= rd_tag;
      for (int s = 1; s < READ_LATENCY; s++) tag_pipe_reg[s] <= tag_pipe_reg[s-1];

      rd_valid <= tag_pipe_reg[READ_LATENCY-1];
      if (|tag_pipe_reg[READ_LATENCY-1]) rd_data <= mem_rdata;

      if (|(req & ~grant) && (stall_cnt != {STALL_CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;

      // Dual read/write from one source, or a request dropped before grant.
      if (|(read_req & write_req) || |(req_prev_reg & ~grant_prev_reg & ~req))
        proto_err <= 1'b1;

      req_prev_reg   <= req;
      grant_prev_reg <= grant;
    end
  end

endmodule
